// File: rtl/picoblaze_int_ctrl_pkg.sv
// Shared definitions for the PicoBlaze interrupt controller.
//   state_t            : controller FSM state encoding
//   DEF_*_PORT_ID      : default I/O port addresses of the register map
package picoblaze_int_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  localparam logic [7:0] DEF_MASK_PORT_ID   = 8'h10;
  localparam logic [7:0] DEF_CLEAR_PORT_ID  = 8'h11;
  localparam logic [7:0] DEF_STATUS_PORT_ID = 8'h12;
  localparam logic [7:0] DEF_VECTOR_PORT_ID = 8'h13;

endpackage

// File: rtl/picoblaze_int_ctrl_if.sv
// PicoBlaze I/O and interrupt bus as seen by a peripheral.
//   port_id/write_strobe/out_port : processor port writes and read address
//   in_port_data                  : registered read data back to the processor
//   interrupt/interrupt_ack       : interrupt request and its acknowledge pulse
// master = processor side, slave = peripheral side.
interface picoblaze_int_ctrl_if;
  logic [7:0] port_id;
  logic       write_strobe;
  logic [7:0] out_port;
  logic [7:0] in_port_data;
  logic       interrupt;
  logic       interrupt_ack;

  modport master (
    output port_id, write_strobe, out_port, interrupt_ack,
    input  in_port_data, interrupt
  );

  modport slave (
    input  port_id, write_strobe, out_port, interrupt_ack,
    output in_port_data, interrupt
  );
endinterface

// File: rtl/picoblaze_prio_enc.sv
// Fixed-priority encoder: lowest set bit of req wins.
//   req   : 8 request bits
//   valid : any bit of req set
//   idx   : index of the lowest set bit (0 when valid is low)
module picoblaze_prio_enc (
  input  logic [7:0] req,
  output logic       valid,
  output logic [2:0] idx
);

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (req[i] && !valid) begin
        valid = 1'b1;
        idx   = i[2:0];
      end
    end
  end

endmodule

// File: rtl/picoblaze_int_ctrl.sv
// Eight-source edge-triggered interrupt controller for a PicoBlaze core.
//   clk, reset_n : clock, asynchronous active-low reset
//   irq_src      : interrupt sources, a rising edge latches a pending bit
//   bus          : PicoBlaze port/interrupt bus (slave side)
// Register map: MASK (r/w enable mask), CLEAR (write-1-to-clear pending),
// STATUS (read pending), VECTOR (read {busy, 4'b0, vec}).
module picoblaze_int_ctrl
  import picoblaze_int_ctrl_pkg::*;
#(
  parameter logic [7:0] MASK_PORT_ID   = DEF_MASK_PORT_ID,
  parameter logic [7:0] CLEAR_PORT_ID  = DEF_CLEAR_PORT_ID,
  parameter logic [7:0] STATUS_PORT_ID = DEF_STATUS_PORT_ID,
  parameter logic [7:0] VECTOR_PORT_ID = DEF_VECTOR_PORT_ID
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [7:0]                 irq_src,
  picoblaze_int_ctrl_if.slave        bus
);

  state_t     state;
  logic [7:0] src_d;
  logic [7:0] irq_edge;
  logic [7:0] pending;
  logic [7:0] mask;
  logic [7:0] active;
  logic [2:0] vec;
  logic       mask_wr;
  logic       clear_wr;
  logic       enc_valid;
  logic [2:0] enc_idx;

  always_comb begin
    irq_edge = irq_src & ~src_d;
    active   = pending & mask;
    mask_wr  = bus.write_strobe && (bus.port_id == MASK_PORT_ID);
    clear_wr = bus.write_strobe && (bus.port_id == CLEAR_PORT_ID);
  end

  picoblaze_prio_enc u_prio_enc (
    .req   (active),
    .valid (enc_valid),
    .idx   (enc_idx)
  );

  // src_d resets high so a source already asserted at reset release
  // does not look like a new edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_d   <= '1;
      pending <= '0;
      mask    <= '0;
    end else begin
      src_d <= irq_src;
      // OR-ing the edge in after the clear lets a new edge win over a clear.
      if (clear_wr) pending <= (pending & ~bus.out_port) | irq_edge;
      else          pending <= pending | irq_edge;
      if (mask_wr)  mask <= bus.out_port;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      vec           <= '0;
      bus.interrupt <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          bus.interrupt <= 1'b0;
          if (enc_valid) begin
            vec           <= enc_idx;
            state         <= ST_ASSERT;
            bus.interrupt <= 1'b1;
          end
        end
        ST_ASSERT: begin
          // Held regardless of mask/clear changes until acknowledged.
          if (bus.interrupt_ack) begin
            state         <= ST_SERVICE;
            bus.interrupt <= 1'b0;
          end
        end
        ST_SERVICE: begin
          bus.interrupt <= 1'b0;
          if (!active[vec]) state <= ST_IDLE;
        end
        default: begin
          state         <= ST_IDLE;
          bus.interrupt <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.in_port_data <= '0;
    end else begin
      case (bus.port_id)
        MASK_PORT_ID:   bus.in_port_data <= mask;
        STATUS_PORT_ID: bus.in_port_data <= pending;
        VECTOR_PORT_ID: bus.in_port_data <= {(state != ST_IDLE), 4'b0000, vec};
        default:        bus.in_port_data <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_picoblaze_int_ctrl.sv
// Directed bench for picoblaze_int_ctrl: expected values are queued when
// stimulus is applied and popped when the corresponding output is sampled.
module tb_picoblaze_int_ctrl;

  localparam logic [7:0] P_MASK   = 8'h10;
  localparam logic [7:0] P_CLEAR  = 8'h11;
  localparam logic [7:0] P_STATUS = 8'h12;
  localparam logic [7:0] P_VECTOR = 8'h13;
  localparam logic [7:0] P_NONE   = 8'h55;

  logic       clk;
  logic       reset_n;
  logic [7:0] irq_src;

  picoblaze_int_ctrl_if bus ();

  picoblaze_int_ctrl #(
    .MASK_PORT_ID   (P_MASK),
    .CLEAR_PORT_ID  (P_CLEAR),
    .STATUS_PORT_ID (P_STATUS),
    .VECTOR_PORT_ID (P_VECTOR)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .irq_src (irq_src),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic push(input string tag, input logic [7:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [7:0] obs);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty: observed %02h with nothing expected", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %02h expected %02h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [7:0] port, input logic [7:0] data);
    bus.port_id      = port;
    bus.out_port     = data;
    bus.write_strobe = 1'b1;
    tick();
    bus.write_strobe = 1'b0;
    bus.port_id      = P_NONE;
  endtask

  task automatic rd(input logic [7:0] port, input string tag, input logic [7:0] exp);
    bus.port_id = port;
    push(tag, exp);
    tick();
    pop_check(bus.in_port_data);
    bus.port_id = P_NONE;
  endtask

  task automatic chk_int(input string tag, input logic exp);
    push(tag, {7'b0, exp});
    pop_check({7'b0, bus.interrupt});
  endtask

  task automatic ack();
    bus.interrupt_ack = 1'b1;
    tick();
    bus.interrupt_ack = 1'b0;
  endtask

  task automatic wait_int(input string tag, input int budget);
    int k;
    k = 0;
    while (bus.interrupt !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    chk_int(tag, 1'b1);
  endtask

  int low_cnt;

  initial begin
    reset_n           = 1'b0;
    irq_src           = 8'h00;
    bus.port_id       = P_NONE;
    bus.out_port      = 8'h00;
    bus.write_strobe  = 1'b0;
    bus.interrupt_ack = 1'b0;

    // reset state
    tick(2);
    chk_int("rst_int", 1'b0);
    push("rst_rdata", 8'h00);
    pop_check(bus.in_port_data);
    reset_n = 1'b1;
    tick();
    rd(P_MASK,   "rst_mask",   8'h00);
    rd(P_STATUS, "rst_status", 8'h00);
    rd(P_VECTOR, "rst_vector", 8'h00);

    // single source, enabled
    wr(P_MASK, 8'h04);
    irq_src = 8'h04;
    tick();
    chk_int("s1_int_pre", 1'b0);
    irq_src = 8'h00;
    rd(P_STATUS, "s1_pending", 8'h04);
    chk_int("s1_int_rise", 1'b1);
    tick();
    chk_int("s1_int_hold", 1'b1);
    ack();
    chk_int("s1_int_ack", 1'b0);
    rd(P_VECTOR, "s1_vector_busy", 8'h82);
    wr(P_CLEAR, 8'h04);
    tick();
    rd(P_VECTOR, "s1_vector_idle", 8'h02);
    rd(P_STATUS, "s1_status_clr", 8'h00);

    // two simultaneous sources, lowest index first
    wr(P_MASK, 8'hFF);
    irq_src = 8'h22;
    tick();
    irq_src = 8'h00;
    wait_int("s2_int_first", 5);
    rd(P_VECTOR, "s2_vector_first", 8'h81);
    ack();
    low_cnt = 1;
    wr(P_CLEAR, 8'h02);
    if (bus.interrupt === 1'b0) low_cnt++;
    while (bus.interrupt !== 1'b1 && low_cnt < 20) begin
      tick();
      if (bus.interrupt === 1'b0) low_cnt++;
    end
    chk_int("s2_int_second", 1'b1);
    push("s2_low_gap_ge2", 8'h01);
    pop_check({7'b0, (low_cnt >= 2)});
    rd(P_VECTOR, "s2_vector_second", 8'h85);
    ack();
    wr(P_CLEAR, 8'h20);
    tick(2);
    // ack while idle is ignored
    ack();
    rd(P_VECTOR, "s2_ack_idle", 8'h05);
    chk_int("s2_ack_idle_int", 1'b0);

    // masked source stays pending; enabling it raises the interrupt
    wr(P_MASK, 8'h00);
    irq_src = 8'h01;
    tick();
    irq_src = 8'h00;
    rd(P_STATUS, "s3_pending_masked", 8'h01);
    tick(2);
    chk_int("s3_no_int", 1'b0);
    wr(P_MASK, 8'h01);
    wait_int("s3_int_unmask", 5);
    rd(P_VECTOR, "s3_vector", 8'h80);
    // mask removed during ASSERT must not drop the request
    wr(P_MASK, 8'h00);
    chk_int("s3_int_mask_hold", 1'b1);
    ack();
    tick(2);
    rd(P_VECTOR, "s3_vector_released", 8'h00);
    rd(P_STATUS, "s3_pending_kept", 8'h01);
    wr(P_CLEAR, 8'h01);

    // edge beats simultaneous clear
    irq_src = 8'h08;
    wr(P_CLEAR, 8'h08);
    rd(P_STATUS, "s4_edge_wins", 8'h08);
    wr(P_CLEAR, 8'h08);
    rd(P_STATUS, "s4_clear_level", 8'h00);
    irq_src = 8'h00;
    // writes to read-only ports are ignored
    wr(P_STATUS, 8'hFF);
    wr(P_VECTOR, 8'hFF);
    rd(P_STATUS, "s4_ro_status", 8'h00);
    rd(P_MASK,   "s4_ro_mask",   8'h00);

    // sources high through reset release
    reset_n = 1'b0;
    irq_src = 8'hFF;
    tick(2);
    reset_n = 1'b1;
    tick(2);
    rd(P_STATUS, "s5_no_edge", 8'h00);

    // reset during ASSERT
    wr(P_MASK, 8'h01);
    irq_src = 8'h00;
    tick();
    irq_src = 8'h01;
    wait_int("s6_int", 5);
    reset_n = 1'b0;
    #1;
    chk_int("s6_async_drop", 1'b0);
    tick();
    reset_n = 1'b1;
    ack();
    chk_int("s6_ack_ignored", 1'b0);
    rd(P_VECTOR, "s6_vector", 8'h00);
    rd(P_STATUS, "s6_status", 8'h00);
    rd(P_NONE,   "s6_unmapped", 8'h00);

    if (sb.size() != 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL sb_leftover: observed %0d entries expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/picoblaze_int_ctrl.md
PICOBLAZE_INT_CTRL -- requirements
Module: picoblaze_int_ctrl

Interface
REQ-001 SHALL have parameter MASK_PORT_ID, default 8'h10, meaning the port that reads and writes the interrupt enable mask.
REQ-002 SHALL have parameter CLEAR_PORT_ID, default 8'h11, meaning the write-1-to-clear port for pending bits.
REQ-003 SHALL have parameter STATUS_PORT_ID, default 8'h12, meaning the read-only port for pending bits.
REQ-004 SHALL have parameter VECTOR_PORT_ID, default 8'h13, meaning the read-only port for the current vector.
REQ-005 clk  input  1  system clock; all state changes on the rising edge.
REQ-006 reset_n  input  1  reset; asynchronous, active-low.
REQ-007 irq_src  input  8  interrupt sources, synchronous to clk; rising edge = request.
REQ-008 port_id  input  8  PicoBlaze port address.
REQ-009 write_strobe  input  1  PicoBlaze output strobe, 1 cycle.
REQ-010 out_port  input  8  PicoBlaze output data.
REQ-011 in_port_data  output  8  read data to PicoBlaze in_port; top level ORs it with other peripherals.
REQ-012 interrupt  output  1  to PicoBlaze interrupt input.
REQ-013 interrupt_ack  input  1  from PicoBlaze interrupt_ack, 1-cycle pulse.

Function
REQ-014 SHALL register irq_src into src_d each cycle; edge[i] = irq_src[i] & ~src_d[i].
REQ-015 SHALL set pending[i] on edge[i]; edge set wins over a simultaneous clear of the same bit.
REQ-016 write_strobe with port_id==MASK_PORT_ID SHALL load mask <= out_port next edge (1 = enabled).
REQ-017 write_strobe with port_id==CLEAR_PORT_ID SHALL do pending <= (pending & ~out_port) | edge.
REQ-018 active = pending & mask; masking SHALL NOT clear pending bits.
REQ-019 Priority SHALL be fixed: lowest set index of active wins.
REQ-020 FSM states: IDLE, ASSERT, SERVICE.
REQ-021 IDLE: if active!=0, latch vec <= winning index and go to ASSERT; interrupt=0.
REQ-022 ASSERT: interrupt=1, registered; hold until interrupt_ack=1, then go to SERVICE. Minimum assertion is 1 cycle; a mask or clear during ASSERT SHALL NOT drop interrupt before ack.
REQ-023 SERVICE: interrupt=0; go to IDLE when active[vec]==0, whether cleared or masked.
REQ-024 Another interrupt SHALL be issued no earlier than 1 cycle after SERVICE->IDLE, so at least 2 low cycles between assertions.
REQ-025 interrupt_ack outside ASSERT SHALL be ignored.
REQ-026 in_port_data SHALL be registered with 1-cycle latency from port_id:
- MASK_PORT_ID -> mask
- STATUS_PORT_ID -> pending
- VECTOR_PORT_ID -> {busy, 4'b0, vec}, where busy = (state!=IDLE)
- any other port_id -> 8'h00
REQ-027 Reads SHALL have no side effects; a write to STATUS_PORT_ID or VECTOR_PORT_ID SHALL be ignored.

Reset
REQ-028 On reset_n=0, the block SHALL immediately set: pending=0, mask=0, vec=0, in_port_data=0, interrupt=0, state=IDLE.
REQ-029 On reset_n=0, src_d SHALL be set to 8'hFF, so a source held high through reset generates no edge.
REQ-030 Reset mid-ASSERT SHALL drop interrupt at once; a subsequent ack SHALL be ignored.

Structure
REQ-031 A shared package/include SHALL hold the FSM state encodings and default port IDs.
REQ-032 SHALL have one sub-module, picoblaze_prio_enc: combinational 8-bit to {valid, 3-bit index}, lowest index first.

Verification
REQ-033 Scenario: mask=8'h04, pulse irq_src[2] -> pending=8'h04, interrupt=1 one cycle later.
- ack -> interrupt=0.
- VECTOR read = 8'h82.
- CLEAR write 8'h04 -> busy=0.
REQ-034 Scenario: mask=8'hFF, irq_src[5] and irq_src[1] rise in the same cycle -> vec=1.
- After clearing bit 1, a second interrupt with vec=5, at least 2 low cycles later.
REQ-035 Scenario: mask=0, pulse irq_src[0] -> pending=8'h01, no interrupt.
- Then write mask=8'h01 -> interrupt next cycles.
REQ-036 Scenario: CLEAR write 8'h08 in the same cycle as an irq_src[3] edge -> pending[3] stays 1.
REQ-037 Scenario: irq_src=8'hFF through reset release -> pending stays 8'h00.
REQ-038 Scenario: reset_n low during ASSERT -> interrupt=0 asynchronously.
- A following ack pulse causes no state change.
- Read of an unmapped port -> in_port_data=8'h00.
